// File: rtl/chimp_click_decoder.sv
// Turns the raw mouse button and pixel coordinates into one-cycle box-select or miss pulses.
// Define CHIMP_CLICK_DEBOUNCE_EN to build the debounce filter; otherwise the synchronised level is used directly.
module chimp_click_decoder #(
  parameter int GRID_X0         = 160,
  parameter int GRID_Y0         = 80,
  parameter int BOX_PX          = 40,
  parameter int GRID_N          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iEnable,
  input  logic       iLeftButton,
  input  logic [9:0] iMouseX,
  input  logic [8:0] iMouseY,
  output logic       oMouseClick,
  output logic       oMissClick,
  output logic [2:0] oBoxX,
  output logic [2:0] oBoxY,
  output logic       oBusy
);

  localparam logic [10:0]        X_LO  = 11'(GRID_X0);
  localparam logic [10:0]        X_HI  = 11'(GRID_X0 + GRID_N * BOX_PX - 1);
  localparam logic [10:0]        Y_LO  = 11'(GRID_Y0);
  localparam logic [10:0]        Y_HI  = 11'(GRID_Y0 + GRID_N * BOX_PX - 1);
  localparam logic signed [10:0] BOX_S = 11'(BOX_PX);

  // Box indices are only 3 bits wide, so larger grids cannot be represented.
  if (GRID_N > 8 || GRID_N < 1 || BOX_PX < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("chimp_click_decoder: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, DIVIDE, EMIT, WAIT_RELEASE} state_t;

  state_t             state;
  state_t             state_next;
  logic               sync_meta;
  logic               sync_out;
  logic               db;
  logic               db_prev;
  logic               press;
  logic               miss;
  logic               in_grid;
  logic               x_done;
  logic               y_done;
  logic               click_pulse;
  logic               miss_pulse;
  logic signed [10:0] rem_x;
  logic signed [10:0] rem_y;
  logic [2:0]         cnt_x;
  logic [2:0]         cnt_y;
  logic [2:0]         box_x;
  logic [2:0]         box_y;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= iLeftButton;
      sync_out  <= sync_meta;
    end
  end

`ifdef CHIMP_CLICK_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;

  // db only follows the synchroniser after a full run of disagreeing cycles.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (sync_out == db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db     <= sync_out;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end
`else
  assign db = sync_out;
`endif

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      db_prev <= 1'b0;
    end else begin
      db_prev <= db;
    end
  end

  assign press   = db & ~db_prev;
  assign in_grid = ({1'b0, iMouseX} >= X_LO) && ({1'b0, iMouseX} <= X_HI) &&
                   ({2'b00, iMouseY} >= Y_LO) && ({2'b00, iMouseY} <= Y_HI);
  assign x_done  = rem_x < BOX_S;
  assign y_done  = rem_y < BOX_S;

  // Quotients come from repeated subtraction; box registers load as DIVIDE exits so they
  // are already valid in the same cycle as the click pulse.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      rem_x <= '0;
      rem_y <= '0;
      cnt_x <= '0;
      cnt_y <= '0;
      miss  <= 1'b0;
      box_x <= '0;
      box_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press && iEnable) begin
            rem_x <= {1'b0, iMouseX} - X_LO;
            rem_y <= {2'b00, iMouseY} - Y_LO;
            cnt_x <= '0;
            cnt_y <= '0;
            miss  <= ~in_grid;
          end
        end
        DIVIDE: begin
          if (!miss) begin
            if (!x_done) begin
              rem_x <= rem_x - BOX_S;
              cnt_x <= cnt_x + 3'd1;
            end
            if (!y_done) begin
              rem_y <= rem_y - BOX_S;
              cnt_y <= cnt_y + 3'd1;
            end
            if (x_done && y_done) begin
              box_x <= cnt_x;
              box_y <= cnt_y;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    click_pulse = 1'b0;
    miss_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (press && iEnable) begin
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        if (miss || (x_done && y_done)) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        click_pulse = ~miss;
        miss_pulse  = miss;
        state_next  = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!db) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign oMouseClick = click_pulse;
  assign oMissClick  = miss_pulse;
  assign oBoxX       = box_x;
  assign oBoxY       = box_y;
  assign oBusy       = (state != IDLE);

endmodule

// File: doc/chimp_click_decoder.md
Name: chimp_click_decoder

Overview:
- Upstream stage of the chimp-test datapath.
- Converts the raw mouse button and pixel coordinates into one-cycle, debounced box-select events: oMouseClick plus oBoxX/oBoxY.
- These outputs feed the datapath's iMouseClick/iBoxX/iBoxY inputs.
- Clicks outside the 8x8 grid produce oMissClick instead.
- Box index is computed by iterative subtraction; there is no divider.

Parameters:
- GRID_X0, 160, left pixel column of the grid.
- GRID_Y0, 80, top pixel row of the grid.
- BOX_PX, 40, box edge length in pixels.
- GRID_N, 8, boxes per side (max 8; indices are 3 bits).
- DEBOUNCE_CYCLES, 16, stable cycles required before a button level change is accepted.

Ports:
- clk  in  1  system clock.
- iResetn  in  1  reset, asynchronous, active-low.
- iEnable  in  1  accept new clicks (driven from the datapath's oDoneLoad).
- iLeftButton  in  1  raw, asynchronous mouse button level.
- iMouseX  in  10  cursor x, in pixels.
- iMouseY  in  9  cursor y, in pixels.
- oMouseClick  out  1  one-cycle pulse: valid in-grid click.
- oMissClick  out  1  one-cycle pulse: click outside the grid.
- oBoxX  out  3  column index of the last valid click.
- oBoxY  out  3  row index of the last valid click.
- oBusy  out  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset: iResetn low asynchronously clears all state; FSM goes to IDLE.
  - All outputs reset to 0; debounced level resets to 0.
  - Reset mid-operation aborts any click in flight with no pulse.
- Input path: iLeftButton passes through a 2-FF synchroniser.
- Debounce: the debounced level db takes the synchronised value only after it differs from db for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreement between the two resets the counter.
- Press event: db rising edge (db & ~db_prev).
- FSM states: IDLE, DIVIDE, EMIT, WAIT_RELEASE.
- IDLE:
  - Press with iEnable=1: latch remX = iMouseX-GRID_X0 and remY = iMouseY-GRID_Y0 (11-bit signed); clear cntX and cntY.
  - Coordinates outside [GRID_X0, GRID_X0+GRID_N*BOX_PX-1] or the Y equivalent set the miss flag; go to DIVIDE.
  - Press with iEnable=0: ignored; stay IDLE.
- DIVIDE, per cycle, for each axis independently:
  - If rem>=BOX_PX: rem -= BOX_PX, cnt += 1.
  - Leave for EMIT on the first cycle in which both rems are < BOX_PX, or immediately if miss is set.
- EMIT, one cycle:
  - In grid: oMouseClick=1; oBoxX/oBoxY load cntX/cntY and hold until the next valid click.
  - Miss: oMissClick=1; oBoxX/oBoxY unchanged.
  - Then go to WAIT_RELEASE.
- WAIT_RELEASE: stay until db=0, then go to IDLE.
  - Holding the button never repeats a click.
- Latency: with edge cycle C0 and quotients qx, qy, the pulse is in cycle C0+max(qx,qy)+2. Worst case is GRID_N+1 cycles after the edge.
  - A miss pulses at C0+2.
- Input changes during the operation:
  - iEnable is sampled only at the press edge; an in-flight click completes even if iEnable falls.
  - iMouseX/iMouseY changes after the latch are ignored.
- Pulse exclusivity: oMouseClick and oMissClick are never high together. Each press yields at most one pulse.
- oBusy = (state != IDLE).

Optional Feature:
- Macro CHIMP_CLICK_DEBOUNCE_EN.
- Defined: the debounce filter is used as described above.
- Undefined: db equals the synchroniser output directly; DEBOUNCE_CYCLES is ignored and no debounce counter is built. Press-to-pulse timing then counts from the synchroniser edge.

Test Plan:
- Reset: iResetn=0 with the button held -> all outputs 0, oBusy=0. Release reset with the button still held -> pulse only after the debounce completes (a fresh rise of db).
- Click at (165,85), button held 40 cycles -> exactly one oMouseClick; oBoxX=0, oBoxY=0; pulse 2 cycles after the db edge.
- Click at (479,399) -> oBoxX=7, oBoxY=7; pulse 9 cycles after the db edge; oBusy high throughout.
- Click at (480,200), then at (159,200) -> one oMissClick each, at edge+2; no oMouseClick; oBoxX/oBoxY keep their previous value.
- Button toggled every 3 cycles for 30 cycles, then stable high, then stable low (macro defined) -> exactly one oMouseClick.
  - Macro undefined: multiple pulses allowed, one per synchroniser rise.
- iEnable=0 at press -> no pulse. iEnable raised while held -> no pulse until release and re-press.
- iResetn pulsed low during DIVIDE -> no pulse; outputs return to 0.
